tb_uart_host_tx: RTL and testbench
==================================

# tb_uart_host_tx

Host-side UART transmitter for the Cheshire simulation environment: the far end of the SoC UART receive path. Testbench byte sources (preload, stdin replay, boot-mode scripts) push bytes through a valid/ready port into a small FIFO. The block serialises them as 8N1/8N2 frames on the line that feeds the SoC's UART RX pin. It works with every testbench configuration (default, RT, embedded) and is independent of AXI data width.

## Interface
- ClkFreqHz, 50_000_000, testbench clock frequency in Hz
- BaudRate, 115_200, line rate in bit/s; ClkDiv = ClkFreqHz / BaudRate (integer division), elaboration error if ClkDiv < 2
- StopBits, 1, stop bits per frame; only 1 or 2 legal (elaboration error otherwise)
- FifoDepth, 8, byte FIFO entries; power of two, ≥ 2
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- en_i  in  1  transmit enable; gates only the start of new frames
- data_i  in  8  byte to send
- valid_i  in  1  data_i valid
- ready_o  out  1  FIFO can accept (= not full)
- tx_o  out  1  serial line, idle high
- busy_o  out  1  FIFO non-empty or frame in progress
- fifo_count_o  out  $clog2(FifoDepth)+1  FIFO occupancy

## Operation
- Reset (rst_ni low at a rising edge): tx_o=1, ready_o=1, busy_o=0, fifo_count_o=0, FSM in IDLE, baud and bit counters 0; FIFO contents discarded. Reset mid-frame aborts the frame immediately: tx_o returns high on the next cycle.
- Push: byte written when valid_i && ready_o at an edge. ready_o = (fifo_count_o != FifoDepth). No write while full; data_i is ignored whenever valid_i is low.
- Simultaneous push and pop at the same edge: the count is unchanged and both take effect. A push while full is impossible because ready_o is low.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE -> START when en_i && FIFO non-empty; the head byte is popped into the shift register on that edge.
  - START: tx_o=0 for ClkDiv cycles -> DATA.
  - DATA: 8 bits, LSB first, ClkDiv cycles each; a bit counter runs 0..7 -> STOP (or PARITY).
  - STOP: tx_o=1 for StopBits*ClkDiv cycles. Exit goes to START with a pop if en_i && FIFO non-empty, otherwise to IDLE.
- The baud counter counts 0..ClkDiv-1 and wraps. A state advances when the counter reaches ClkDiv-1.
- en_i deassertion mid-frame does not truncate: the current frame completes and no new frame starts.
- busy_o = (fifo_count_o != 0) || (state != IDLE).

## Timing
- tx_o, busy_o and fifo_count_o are registered. ready_o is combinational from the count register.
- Latency: handshake at edge N -> FIFO non-empty after N -> pop and START at edge N+1 -> tx_o low from edge N+1 onward. With en_i high and the FSM idle, the start bit begins one cycle after acceptance.
- Frame duration: (1 + 8 + StopBits) * ClkDiv cycles, or one ClkDiv more with parity.
- Back-to-back frames have no idle gap: the start bit of frame k+1 follows the last stop-bit cycle of frame k directly.
- The throughput bound is one byte per frame time. The FIFO absorbs bursts of up to FifoDepth bytes, plus one byte already in the shift register.

## Configuration
- TB_UART_TX_PARITY_EN
  - Defined: the PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for ClkDiv cycles, and the frame grows by ClkDiv cycles.
  - Undefined: the PARITY state and its logic do not exist, and frames are strictly 8N1/8N2.

## Test plan
All scenarios use ClkFreqHz=1_600_000 and BaudRate=100_000, so ClkDiv=16.
- Reset -> tx_o=1, ready_o=1, busy_o=0, fifo_count_o=0; rst_ni pulsed mid-frame -> tx_o=1 and busy_o=0 one cycle after the reset edge.
- Push 0xA5 with en_i=1, StopBits=1 -> tx_o low starting 1 cycle after the handshake for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high. busy_o drops exactly 160 cycles after the pop.
- Burst of 10 bytes 0x00..0x09 with FifoDepth=8 -> ready_o low once the count reaches 8. All 10 bytes are sent in order with no gaps between frames, for 1600 cycles total.
- en_i=0 while pushing 3 bytes -> tx_o stays 1 and fifo_count_o=3. Raise en_i -> 3 frames follow. Drop en_i mid-frame 1 -> frame 1 completes and the FSM returns to IDLE with count=2.
- StopBits=2 and byte 0xFF -> the line stays high for 32 cycles after the data bits; the next start bit follows immediately.
- TB_UART_TX_PARITY_EN defined: 0x07 gives parity 1 and 0x03 gives parity 0, each in bit slot 10; the frame is 176 cycles.

Source files
------------

// File: rtl/tb_uart_host_tx.sv
// Host-side UART transmitter: byte FIFO feeding an 8N1/8N2 serialiser that drives the SoC RX pin.
// Optional even-parity slot between data and stop bits when TB_UART_TX_PARITY_EN is defined.
module tb_uart_host_tx #(
    parameter int unsigned ClkFreqHz = 50_000_000,
    parameter int unsigned BaudRate  = 115_200,
    parameter int unsigned StopBits  = 1,
    parameter int unsigned FifoDepth = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic [7:0]                   data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         tx_o,
    output logic                         busy_o,
    output logic [$clog2(FifoDepth):0]   fifo_count_o
);

    localparam int unsigned ClkDiv = ClkFreqHz / BaudRate;
    localparam int unsigned BaudW  = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam int unsigned PtrW   = $clog2(FifoDepth);
    localparam int unsigned CntW   = PtrW + 1;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(ClkDiv - 1);
    localparam logic [2:0]       StopLast = 3'(StopBits - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FifoDepth);

    if (ClkDiv < 2) begin : g_chk_div
        $error("tb_uart_host_tx: ClkFreqHz / BaudRate must be at least 2");
    end
    if (StopBits != 1 && StopBits != 2) begin : g_chk_stop
        $error("tb_uart_host_tx: StopBits must be 1 or 2");
    end
    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_chk_depth
        $error("tb_uart_host_tx: FifoDepth must be a power of two >= 2");
    end

`ifdef TB_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]        mem [FifoDepth];
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              push, pop, baud_tick, fifo_empty;
    logic [7:0]        head;
`ifdef TB_UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign ready_o      = (count_q != CntFull);
    assign fifo_empty   = (count_q == '0);
    assign head         = mem[rd_ptr_q];
    assign push         = valid_i && ready_o;
    assign baud_tick    = (baud_q == BaudLast);
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign fifo_count_o = count_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef TB_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) begin
            baud_d = baud_tick ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (en_i && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    shift_d = head;
`ifdef TB_UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
`ifdef TB_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef TB_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // bit_q counts stop bits here so 8N2 reuses the same baud counter
                if (baud_tick) begin
                    if (bit_q == StopLast) begin
                        bit_d = '0;
                        if (en_i && !fifo_empty) begin
                            pop     = 1'b1;
                            state_d = START;
                            shift_d = head;
`ifdef TB_UART_TX_PARITY_EN
                            par_d   = ^head;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level and busy flag are registered from next-state values
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef TB_UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
        count_d = count_q + CntW'(push) - CntW'(pop);
        busy_d  = (count_d != '0) || (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            count_q  <= count_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Datapath storage carries no reset; contents are only read after a push or pop
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= data_i;
        shift_q <= shift_d;
`ifdef TB_UART_TX_PARITY_EN
        par_q   <= par_d;
`endif
    end

endmodule

// File: tb/tb_tb_uart_host_tx.sv
// Directed bench for tb_uart_host_tx at ClkDiv=16: frame vectors, burst, enable gating, reset, 8N2.
module tb_tb_uart_host_tx;

`ifdef TB_UART_TX_PARITY_EN
    localparam int PAR_SLOTS = 1;
`else
    localparam int PAR_SLOTS = 0;
`endif
    localparam int FRAME_SLOTS = 10 + PAR_SLOTS;
    localparam int FRAME_CYC   = FRAME_SLOTS * 16;
    localparam int BURST_CYC   = 10 * FRAME_CYC + 60;
    localparam int SS2         = 16 * (9 + PAR_SLOTS);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, valid, ready, tx, busy;
    logic [7:0] data;
    logic [3:0] cnt;
    logic       en2, valid2, ready2, tx2, busy2;
    logic [7:0] data2;
    logic [3:0] cnt2;

    int n_vec  = 0;
    int n_fail = 0;

    logic cap_tx   [BURST_CYC];
    logic cap_busy [BURST_CYC];
    logic cap2     [SS2 + 49];

    always #5 clk = ~clk;

    tb_uart_host_tx #(.ClkFreqHz(1_600_000), .BaudRate(100_000), .StopBits(1), .FifoDepth(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .data_i(data), .valid_i(valid),
        .ready_o(ready), .tx_o(tx), .busy_o(busy), .fifo_count_o(cnt)
    );

    tb_uart_host_tx #(.ClkFreqHz(1_600_000), .BaudRate(100_000), .StopBits(2), .FifoDepth(8)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en2), .data_i(data2), .valid_i(valid2),
        .ready_o(ready2), .tx_o(tx2), .busy_o(busy2), .fifo_count_o(cnt2)
    );

    typedef struct {
        logic [7:0] data;
        logic [8:0] exp_frame;  // slot 0 = start bit, slots 1..8 = data LSB first
        logic       exp_par;
    } vec_t;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Call right after the pop edge; returns at pop + FRAME_CYC - 8
    task automatic sample_frame(output logic [7:0] b, output logic [1:0] fr);
        tick(8);
        fr[1] = tx;
        for (int j = 0; j < 8; j++) begin
            tick(16);
            b[j] = tx;
        end
        tick(16 * (FRAME_SLOTS - 9));
        fr[0] = tx;
    endtask

    initial begin
        vec_t       vecs [6];
        logic       exp_bit;
        logic [7:0] b;
        logic [1:0] fr;
        int         idx, max_cnt, full_ready_bad, lows;

        vecs[0] = '{8'hA5, 9'b101001010, 1'b0};
        vecs[1] = '{8'h00, 9'b000000000, 1'b0};
        vecs[2] = '{8'hFF, 9'b111111110, 1'b0};
        vecs[3] = '{8'h07, 9'b000001110, 1'b1};
        vecs[4] = '{8'h03, 9'b000000110, 1'b0};
        vecs[5] = '{8'h80, 9'b100000000, 1'b1};

        rst_n = 1'b0; en = 1'b0; valid = 1'b0; data = 8'h00;
        en2 = 1'b0; valid2 = 1'b0; data2 = 8'h00;
        tick(3);
        check("rst_tx", tx, 1);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_count", cnt, 0);
        check("rst_tx2", tx2, 1);
        rst_n = 1'b1;
        tick(2);
        check("idle_tx", tx, 1);
        check("idle_busy", busy, 0);

        // Single-frame vectors
        en = 1'b1;
        foreach (vecs[i]) begin
            valid = 1'b1; data = vecs[i].data;
            tick(1);
            valid = 1'b0; data = 8'h00;
            check("v_pre_tx", tx, 1);
            check("v_pre_count", cnt, 1);
            check("v_pre_busy", busy, 1);
            tick(1);
            check("v_start_tx", tx, 0);
            check("v_start_count", cnt, 0);
            tick(8);
            for (int s = 0; s < FRAME_SLOTS; s++) begin
                if (s > 0) tick(16);
                if (s < 9) exp_bit = vecs[i].exp_frame[s];
                else if (PAR_SLOTS != 0 && s == 9) exp_bit = vecs[i].exp_par;
                else exp_bit = 1'b1;
                check($sformatf("v%0d_slot%0d", i, s), tx, exp_bit);
            end
            tick(7);
            check("v_busy_last", busy, 1);
            tick(1);
            check("v_busy_drop", busy, 0);
            check("v_end_tx", tx, 1);
        end

        // Burst of 10 bytes into an 8-deep FIFO
        idx = 0; max_cnt = 0; full_ready_bad = 0;
        for (int c = 0; c < BURST_CYC; c++) begin
            if (idx < 10 && ready) begin
                valid = 1'b1; data = 8'(idx); idx++;
            end else begin
                valid = 1'b0;
            end
            tick(1);
            cap_tx[c] = tx;
            cap_busy[c] = busy;
            if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
            if (cnt == 4'd8 && ready) full_ready_bad++;
        end
        valid = 1'b0;
        check("burst_accepted", idx, 10);
        check("burst_max_count", max_cnt, 8);
        check("burst_ready_full", full_ready_bad, 0);
        check("burst_latency", {cap_tx[0], cap_tx[1]}, 2'b10);
        for (int k = 0; k < 10; k++) begin
            int base;
            base = 1 + k * FRAME_CYC;
            for (int j = 0; j < 8; j++) b[j] = cap_tx[base + 8 + 16 * (j + 1)];
            check($sformatf("burst_byte%0d", k), b, k);
            check($sformatf("burst_frame%0d", k),
                  {cap_tx[base + 8], cap_tx[base + 8 + 16 * (FRAME_SLOTS - 1)]}, 2'b01);
        end
        check("burst_busy_last", cap_busy[10 * FRAME_CYC], 1);
        check("burst_busy_drop", cap_busy[10 * FRAME_CYC + 1], 0);
        check("burst_idle_tx", cap_tx[10 * FRAME_CYC + 1], 1);

        // Enable gating
        en = 1'b0;
        valid = 1'b1; data = 8'h11; tick(1);
        data = 8'h22; tick(1);
        data = 8'h33; tick(1);
        valid = 1'b0;
        lows = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (tx == 1'b0) lows++;
        end
        check("en0_line_low_cycles", lows, 0);
        check("en0_count", cnt, 3);
        check("en0_busy", busy, 1);
        en = 1'b1;
        tick(1);
        check("en1_start_tx", tx, 0);
        check("en1_count", cnt, 2);
        en = 1'b0;
        sample_frame(b, fr);
        check("en_frame1_byte", b, 8'h11);
        check("en_frame1_framing", fr, 2'b01);
        tick(8);
        check("en_drop_tx", tx, 1);
        check("en_drop_count", cnt, 2);
        tick(40);
        check("en_hold_tx", tx, 1);
        check("en_hold_count", cnt, 2);
        check("en_hold_busy", busy, 1);

        // Reset in the middle of a frame
        en = 1'b1;
        tick(1);
        check("en2_start_tx", tx, 0);
        check("en2_count", cnt, 1);
        tick(40);
        rst_n = 1'b0;
        tick(1);
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_count", cnt, 0);
        check("midrst_ready", ready, 1);
        rst_n = 1'b1;
        tick(20);
        check("postrst_tx", tx, 1);
        check("postrst_busy", busy, 0);

        // Two stop bits, back-to-back second frame
        en2 = 1'b1;
        valid2 = 1'b1; data2 = 8'hFF; tick(1);
        data2 = 8'h00; tick(1);
        valid2 = 1'b0;
        check("sb2_start_tx", tx2, 0);
        check("sb2_count", cnt2, 1);
        for (int c = 1; c <= SS2 + 48; c++) begin
            tick(1);
            cap2[c] = tx2;
        end
        lows = 0;
        for (int c = SS2; c < SS2 + 32; c++) if (cap2[c] == 1'b0) lows++;
        check("sb2_stop_low_cycles", lows, 0);
        exp_bit = (PAR_SLOTS != 0) ? 1'b0 : 1'b1;
        check("sb2_last_slot", cap2[SS2 - 8], exp_bit);
        check("sb2_next_start", cap2[SS2 + 32], 0);
        check("sb2_next_start_end", cap2[SS2 + 47], 0);
        tick(250);
        check("sb2_drain_busy", busy2, 0);
        check("sb2_drain_tx", tx2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
